friet_p_rc_rev_seq: RTL and testbench

//  Round-constant sequencer for the inverse Friet-P permutation (decryption/unwrap path).

---
 rtl/friet_p_rc_pkg.sv | 28 ++
 rtl/friet_p_rc_inv.sv | 17 +
 rtl/friet_p_rc_rev_seq.sv | 148 ++++++++++++++
 tb/tb_friet_p_rc_rev_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/friet_p_rc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : friet_p_rc_pkg
// Brief   : Shared types and LFSR step functions for Friet-P round constants.
// Revision: 1.0
// ============================================================================
package friet_p_rc_pkg;

  localparam int RC_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    EMIT = 2'd2
  } rc_state_t;

  // Forward step: next round constant from the current one.
  function automatic logic [RC_W-1:0] rc_fwd(input logic [RC_W-1:0] r);
    rc_fwd = {~r[4], r[2], r[1], r[0], r[0] ^ r[3]};
  endfunction

  // Inverse step: previous round constant from the current one.
  function automatic logic [RC_W-1:0] rc_inv(input logic [RC_W-1:0] n);
    rc_inv = {~n[4], n[0] ^ n[1], n[3], n[2], n[1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/friet_p_rc_inv.sv
`default_nettype none
// ============================================================================
// Module  : friet_p_rc_inv
// Brief   : Combinational inverse round-constant step (reverse LFSR walk).
// Revision: 1.0
// ============================================================================
module friet_p_rc_inv
  import friet_p_rc_pkg::*;
(
  input  logic [RC_W-1:0] i_rc,
  output logic [RC_W-1:0] o_rc
);

  assign o_rc = rc_inv(i_rc);

endmodule
`default_nettype wire

// File: rtl/friet_p_rc_rev_seq.sv
`default_nettype none
// ============================================================================
// Module  : friet_p_rc_rev_seq
// Brief   : Emits Friet-P round constants last round first over valid/ready.
//           Optional macro FRIET_P_RC_REV_CACHE_EN keeps the last constant so
//           later sequences skip the forward seek.
// Revision: 1.0
// ============================================================================
module friet_p_rc_rev_seq
  import friet_p_rc_pkg::*;
#(
  parameter int              NUM_ROUNDS = 24,
  parameter logic [RC_W-1:0] RC_INIT    = 5'h1F
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  output logic                                                  busy,
  output logic [RC_W-1:0]                                       rc_out,
  output logic [((NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1)-1:0] rc_round,
  output logic                                                  rc_valid,
  input  logic                                                  rc_ready,
  output logic                                                  rc_last,
  output logic                                                  done
);

  localparam int            RW          = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RW-1:0] c_round_max = RW'(NUM_ROUNDS - 1);
  localparam logic [RW-1:0] c_seek_last = RW'((NUM_ROUNDS > 1) ? NUM_ROUNDS - 2 : 0);
  localparam bit            c_single    = (NUM_ROUNDS == 1);

  rc_state_t       r_state;
  logic [RC_W-1:0] r_rc;
  logic [RW-1:0]   r_cnt;
  logic [RW-1:0]   r_round;
  logic            r_valid;
  logic            r_busy;
  logic            r_last;
  logic            r_done;

  logic [RC_W-1:0] w_rc_fwd;
  logic [RC_W-1:0] w_rc_inv;
  logic [RC_W-1:0] w_start_rc;
  logic            w_cache_hit;
  logic            w_seek_end;

  assign w_rc_fwd   = rc_fwd(r_rc);
  assign w_seek_end = (r_state == SEEK) && (r_cnt == c_seek_last);

  friet_p_rc_inv u_inv (
    .i_rc (r_rc),
    .o_rc (w_rc_inv)
  );

`ifdef FRIET_P_RC_REV_CACHE_EN
  logic [RC_W-1:0] r_cache_rc;
  logic            r_cache_vld;

  // Only the first completed seek after reset fills the cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_rc  <= '0;
      r_cache_vld <= 1'b0;
    end else if (w_seek_end && !r_cache_vld) begin
      r_cache_rc  <= w_rc_fwd;
      r_cache_vld <= 1'b1;
    end
  end

  assign w_cache_hit = r_cache_vld;
  assign w_start_rc  = r_cache_vld ? r_cache_rc : RC_INIT;
`else
  assign w_cache_hit = 1'b0;
  assign w_start_rc  = RC_INIT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rc    <= '0;
      r_cnt   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rc    <= w_start_rc;
            r_cnt   <= '0;
            r_round <= c_round_max;
            r_busy  <= 1'b1;
            if (c_single || w_cache_hit) begin
              r_state <= EMIT;
              r_valid <= 1'b1;
              r_last  <= c_single;
            end else begin
              r_state <= SEEK;
            end
          end
        end
        SEEK: begin
          r_rc  <= w_rc_fwd;
          r_cnt <= r_cnt + RW'(1);
          if (w_seek_end) begin
            r_state <= EMIT;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        EMIT: begin
          // Everything holds while the consumer stalls.
          if (rc_ready) begin
            if (r_round == '0) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rc    <= w_rc_inv;
              r_round <= r_round - RW'(1);
              r_last  <= (r_round == RW'(1));
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign rc_out   = r_rc;
  assign rc_round = r_round;
  assign rc_valid = r_valid;
  assign rc_last  = r_last;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_friet_p_rc_rev_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_friet_p_rc_rev_seq
// Brief   : Scoreboard bench for the reverse round-constant sequencer
//           (3-round and 24-round instances, cache-aware latency).
// Revision: 1.0
// ============================================================================
module tb_friet_p_rc_rev_seq;

  localparam logic [4:0] RC_INIT = 5'h1F;
`ifdef FRIET_P_RC_REV_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic       start3, start24, ready3, ready24;
  logic       b3, v3, l3, d3, b24, v24, l24, d24;
  logic [4:0] rc3, rc24, rd24;
  logic [1:0] rd3;

  assign start3  = start & ~sel;
  assign start24 = start & sel;
  assign ready3  = ready & ~sel;
  assign ready24 = ready & sel;

  friet_p_rc_rev_seq #(.NUM_ROUNDS(3), .RC_INIT(RC_INIT)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(b3), .rc_out(rc3), .rc_round(rd3),
    .rc_valid(v3), .rc_ready(ready3), .rc_last(l3), .done(d3)
  );

  friet_p_rc_rev_seq #(.NUM_ROUNDS(24), .RC_INIT(RC_INIT)) dut24 (
    .clk(clk), .rst(rst), .start(start24), .busy(b24), .rc_out(rc24), .rc_round(rd24),
    .rc_valid(v24), .rc_ready(ready24), .rc_last(l24), .done(d24)
  );

  logic       busy, valid, last, done_o;
  logic [4:0] rc, round;
  assign busy   = sel ? b24 : b3;
  assign valid  = sel ? v24 : v3;
  assign last   = sel ? l24 : l3;
  assign done_o = sel ? d24 : d3;
  assign rc     = sel ? rc24 : rc3;
  assign round  = sel ? rd24 : {3'b000, rd3};

  int         checks = 0;
  int         errors = 0;
  logic [9:0] q[$];

  function automatic logic [4:0] model_fwd(input logic [4:0] r);
    return {~r[4], r[2], r[1], r[0], r[0] ^ r[3]};
  endfunction

  task automatic push_expected(input int n);
    logic [4:0] rcs[32];
    rcs[0] = RC_INIT;
    for (int i = 1; i < n; i++) rcs[i] = model_fwd(rcs[i-1]);
    for (int k = 0; k < n; k++) q.push_back({5'(n - 1 - k), rcs[n-1-k]});
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_seq(input int exp_lat, input int stall_beat, input int stall_len,
                         input bit hold, input string name);
    int lat, beat, stalled, cyc;
    logic [9:0] e;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = 1;
    while (!valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    end
    beat = 0; stalled = 0; cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      e = q[0];
      ready = !(beat == stall_beat && stalled < stall_len);
      checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || rc !== e[4:0] || round !== e[9:5] ||
          last !== (e[9:5] == 5'd0)) begin
        errors++;
        $display("FAIL %s beat %0d: valid=%b busy=%b rc=%h round=%0d last=%b, expected valid=1 busy=1 rc=%h round=%0d last=%b",
                 name, beat, valid, busy, rc, round, last, e[4:0], e[9:5], (e[9:5] == 5'd0));
      end
      if (ready) begin void'(q.pop_front()); beat++; end
      else stalled++;
      @(posedge clk); #1;
      cyc++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL %s drain timeout: %0d beats left, expected 0", name, q.size());
      q.delete();
    end
    ready = 1'b1;
    checks++;
    if (done_o !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse: done=%b valid=%b busy=%b, expected 1 0 0", name, done_o, valid, busy);
    end
    if (!hold) begin
      @(posedge clk); #1;
      checks++;
      if (done_o !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s done width: done=%b busy=%b, expected 0 0", name, done_o, busy);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || done_o !== 1'b0 || last !== 1'b0 ||
          rc !== 5'h00 || round !== 5'd0) begin
        errors++;
        $display("FAIL reset sel=%0d: valid=%b busy=%b done=%b last=%b rc=%h round=%0d, expected all 0",
                 s, valid, busy, done_o, last, rc, round);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    sel = 1'b0;
    q.push_back({5'd2, 5'h1D});
    q.push_back({5'd1, 5'h0E});
    q.push_back({5'd0, 5'h1F});
    run_seq(3, -1, 0, 1'b0, "basic3");
  endtask

  task automatic test_stall();
    do_reset();
    sel = 1'b0;
    q.push_back({5'd2, 5'h1D});
    q.push_back({5'd1, 5'h0E});
    q.push_back({5'd0, 5'h1F});
    run_seq(3, 1, 4, 1'b0, "stall3");
  endtask

  task automatic test_default();
    do_reset();
    sel = 1'b1;
    push_expected(24);
    run_seq(24, -1, 0, 1'b0, "default24");
  endtask

  task automatic test_hold_start();
    do_reset();
    sel = 1'b1;
    push_expected(24);
    run_seq(24, -1, 0, 1'b1, "hold_run1");
    push_expected(24);
    run_seq(CACHE ? 1 : 24, -1, 0, 1'b0, "hold_run2");
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    sel = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid wait: valid=%b, expected 1", valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done_o !== 1'b0 || last !== 1'b0 ||
        rc !== 5'h00 || round !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid abort: valid=%b busy=%b done=%b last=%b rc=%h round=%0d, expected all 0",
               valid, busy, done_o, last, rc, round);
    end
    rst = 1'b0;
    push_expected(24);
    run_seq(24, -1, 0, 1'b0, "rst_mid_replay");
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel = 1'b1;
    push_expected(24);
    run_seq(24, 3, 2, 1'b0, "b2b_run1");
    push_expected(24);
    run_seq(CACHE ? 1 : 24, -1, 0, 1'b0, "b2b_run2");
    do_reset();
    push_expected(24);
    run_seq(24, -1, 0, 1'b0, "b2b_after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_default();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
